// File: rtl/muldiv_iter.sv
// Iterative MUL/MADD/DIV unit: radix-2 shift-add multiplier and restoring divider
// sharing one 2W accumulator, with a single sign-fix cycle before the result.
module muldiv_iter #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [1:0]            op,
  input  logic                  op_u,
  input  logic [DATA_WIDTH-1:0] a,
  input  logic [DATA_WIDTH-1:0] b,
  input  logic [DATA_WIDTH-1:0] hi_in,
  input  logic [DATA_WIDTH-1:0] lo_in,
  input  logic                  kill,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi_out,
  output logic [DATA_WIDTH-1:0] lo_out,
  output logic                  div_by_zero
);

  localparam int unsigned W    = DATA_WIDTH;
  localparam int unsigned W2   = 2 * DATA_WIDTH;
  localparam int unsigned CW   = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
  typedef enum logic [1:0] {OP_MUL = 2'b00, OP_MADD = 2'b01, OP_DIV = 2'b10, OP_RSV = 2'b11} op_t;

  state_t          state_q, state_d;
  op_t             op_q, op_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W2-1:0]   acc_q, acc_d;
  logic [W-1:0]    opnd_q, opnd_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [W-1:0]    hin_q, hin_d, lin_q, lin_d;
  logic            res_neg_q, res_neg_d, rem_neg_q, rem_neg_d;
  logic [W-1:0]    hi_q, hi_d, lo_q, lo_d;
  logic            dbz_q, dbz_d;

  logic            accept, load, a_neg, b_neg, div_ok;
  logic [W-1:0]    a_mag, b_mag, div_diff, quo, rem;
  logic [W:0]      mul_sum, rem_sh;
  logic [W2-1:0]   mul_next, div_next, prod;

  always_comb begin
    accept = start && (op != OP_RSV) && !kill;
    a_neg  = !op_u && a[W-1];
    b_neg  = !op_u && b[W-1];
    a_mag  = a_neg ? (~a + W'(1)) : a;
    b_mag  = b_neg ? (~b + W'(1)) : b;

    // Multiply: acc = {partial sum, remaining multiplier bits}; the add carry shifts in at the top.
    mul_sum  = {1'b0, acc_q[W2-1:W]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    mul_next = {mul_sum, acc_q[W-1:1]};

    // Divide: acc = {remainder, dividend/quotient}; shifted remainder needs one extra bit.
    rem_sh   = acc_q[W2-1:W-1];
    div_ok   = rem_sh >= {1'b0, opnd_q};
    div_diff = rem_sh[W-1:0] - opnd_q;
    div_next = div_ok ? {div_diff, acc_q[W-2:0], 1'b1} : {rem_sh[W-1:0], acc_q[W-2:0], 1'b0};

    prod = (res_neg_q ? (~acc_q + W2'(1)) : acc_q) + ((op_q == OP_MADD) ? {hin_q, lin_q} : '0);
    quo  = res_neg_q ? (~acc_q[W-1:0] + W'(1)) : acc_q[W-1:0];
    rem  = rem_neg_q ? (~acc_q[W2-1:W] + W'(1)) : acc_q[W2-1:W];
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    opnd_d    = opnd_q;
    a_d       = a_q;
    b_d       = b_q;
    hin_d     = hin_q;
    lin_d     = lin_q;
    res_neg_d = res_neg_q;
    rem_neg_d = rem_neg_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;
    load      = 1'b0;

    case (state_q)
      IDLE: if (accept) begin
        load    = 1'b1;
        state_d = CALC;
      end
      CALC: if (kill) begin
        state_d = IDLE;
      end else begin
        acc_d = (op_q == OP_DIV) ? div_next : mul_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = FIX;
      end
      FIX: if (kill) begin
        state_d = IDLE;
      end else begin
        state_d = DONE;
        if (op_q != OP_DIV) begin
          hi_d = prod[W2-1:W];
          lo_d = prod[W-1:0];
        end else if (b_q == '0) begin
          hi_d  = a_q;
          lo_d  = '1;
          dbz_d = 1'b1;
        end else begin
          hi_d = rem;
          lo_d = quo;
        end
      end
      DONE: if (accept) begin
        load    = 1'b1;
        state_d = CALC;
      end else begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      op_d      = op_t'(op);
      a_d       = a;
      b_d       = b;
      hin_d     = hi_in;
      lin_d     = lo_in;
      res_neg_d = !op_u && (a[W-1] ^ b[W-1]);
      rem_neg_d = a_neg;
      cnt_d     = '0;
      dbz_d     = 1'b0;
      if (op == OP_DIV) begin
        acc_d  = {W'(0), a_mag};
        opnd_d = b_mag;
      end else begin
        acc_d  = {W'(0), b_mag};
        opnd_d = a_mag;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      op_q      <= OP_MUL;
      cnt_q     <= '0;
      acc_q     <= '0;
      opnd_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      hin_q     <= '0;
      lin_q     <= '0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      opnd_q    <= opnd_d;
      a_q       <= a_d;
      b_q       <= b_d;
      hin_q     <= hin_d;
      lin_q     <= lin_d;
      res_neg_q <= res_neg_d;
      rem_neg_q <= rem_neg_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign hi_out      = hi_q;
  assign lo_out      = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_iter.sv
// Bench for muldiv_iter: directed vector table, multi-cycle corner sequences,
// and random operations checked against an arithmetic reference model.
module tb_muldiv_iter;
  localparam int W = 32;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic          op_u = 1'b0;
  logic [W-1:0]  a = '0, b = '0, hi_in = '0, lo_in = '0;
  logic          kill = 1'b0;
  logic          busy, done, div_by_zero;
  logic [W-1:0]  hi_out, lo_out;

  int checks = 0;
  int errors = 0;

  muldiv_iter #(.DATA_WIDTH(W)) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .op(op), .op_u(op_u),
    .a(a), .b(b), .hi_in(hi_in), .lo_in(lo_in), .kill(kill),
    .busy(busy), .done(done), .hi_out(hi_out), .lo_out(lo_out),
    .div_by_zero(div_by_zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0]  op;
    logic        u;
    logic [31:0] a, b, hi, lo;
    logic [31:0] eh, el;
    logic        edz;
  } vec_t;

  vec_t vt[$];

  task automatic add_vec(input logic [1:0] o, input logic u, input logic [31:0] ai, bi, hi, lo,
                         input logic [31:0] eh, el, input logic edz);
    vec_t v;
    v.op = o; v.u = u; v.a = ai; v.b = bi; v.hi = hi; v.lo = lo;
    v.eh = eh; v.el = el; v.edz = edz;
    vt.push_back(v);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic; returns {div_by_zero, hi, lo}.
  function automatic logic [64:0] model(input logic [1:0] o, input logic u,
                                        input logic [31:0] ai, bi, hi, lo);
    logic [63:0] p;
    longint sa, sb, sq, sr;
    logic [63:0] q64, r64;
    sa = longint'($signed(ai));
    sb = longint'($signed(bi));
    if (o == 2'd2) begin
      if (bi == 0) return {1'b1, ai, 32'hFFFFFFFF};
      if (u) return {1'b0, ai % bi, ai / bi};
      sq = sa / sb;
      sr = sa % sb;
      q64 = sq;
      r64 = sr;
      return {1'b0, r64[31:0], q64[31:0]};
    end
    if (u) p = {32'b0, ai} * {32'b0, bi};
    else   p = sa * sb;
    if (o == 2'd1) p = p + {hi, lo};
    return {1'b0, p};
  endfunction

  task automatic do_op(input logic [1:0] o, input logic u, input logic [31:0] ai, bi, hi, lo,
                       output logic [31:0] rh, rl, output logic rdz, output int lat, output int bcnt);
    @(negedge clock);
    op = o; op_u = u; a = ai; b = bi; hi_in = hi; lo_in = lo; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    lat = 0; bcnt = 0; rh = '0; rl = '0; rdz = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clock);
      if (busy) bcnt++;
      if (done) begin
        lat = i; rh = hi_out; rl = lo_out; rdz = div_by_zero;
        break;
      end
    end
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h1;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] rh, rl, ph, pl;
    logic        rdz, pdz, saw_done, bubble;
    logic [64:0] exp;
    int          lat, bcnt, gap;
    logic [1:0]  ro;
    logic        ru;
    logic [31:0] ra, rb, rhi, rlo;

    add_vec(2'd0, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    add_vec(2'd0, 1'b0, 32'hFFFFFFFD, 32'd7, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    add_vec(2'd0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0, 32'h0, 32'h1, 1'b0);
    add_vec(2'd1, 1'b0, 32'd1, 32'd1, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0, 1'b0);
    add_vec(2'd1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h0, 1'b0);
    add_vec(2'd2, 1'b1, 32'd100, 32'd7, 0, 0, 32'd2, 32'd14, 1'b0);
    add_vec(2'd2, 1'b0, 32'hFFFFFFF9, 32'd2, 0, 0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    add_vec(2'd2, 1'b0, 32'd7, 32'hFFFFFFFE, 0, 0, 32'd1, 32'hFFFFFFFD, 1'b0);
    add_vec(2'd2, 1'b0, 32'h80000000, 32'hFFFFFFFF, 0, 0, 32'h0, 32'h80000000, 1'b0);
    add_vec(2'd2, 1'b0, 32'hFFFFFFF0, 32'd0, 0, 0, 32'hFFFFFFF0, 32'hFFFFFFFF, 1'b1);
    add_vec(2'd2, 1'b1, 32'h00001234, 32'd0, 0, 0, 32'h00001234, 32'hFFFFFFFF, 1'b1);
    add_vec(2'd0, 1'b1, 32'd2, 32'd3, 0, 0, 32'd0, 32'd6, 1'b0);

    // Reset state
    repeat (2) @(negedge clock);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_hi", 64'(hi_out), 64'd0);
    chk("reset_lo", 64'(lo_out), 64'd0);
    chk("reset_dbz", 64'(div_by_zero), 64'd0);
    reset_n = 1'b1;

    // Directed table
    foreach (vt[i]) begin
      do_op(vt[i].op, vt[i].u, vt[i].a, vt[i].b, vt[i].hi, vt[i].lo, rh, rl, rdz, lat, bcnt);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'd34);
      chk($sformatf("vec%0d_busy_cycles", i), 64'(bcnt), 64'd34);
      chk($sformatf("vec%0d_hi", i), 64'(rh), 64'(vt[i].eh));
      chk($sformatf("vec%0d_lo", i), 64'(rl), 64'(vt[i].el));
      chk($sformatf("vec%0d_dbz", i), 64'(rdz), 64'(vt[i].edz));
    end

    // Reserved op and start-with-kill are not accepted
    @(negedge clock);
    op = 2'd3; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("reserved_op_busy", 64'(busy), 64'd0);
    op = 2'd0; start = 1'b1; kill = 1'b1;
    @(negedge clock);
    start = 1'b0; kill = 1'b0;
    chk("start_kill_idle_busy", 64'(busy), 64'd0);
    chk("idle_outputs_held", {hi_out, lo_out}, 64'd6);

    // Kill mid-operation; a second start during CALC is ignored
    @(negedge clock);
    ph = hi_out; pl = lo_out; pdz = div_by_zero;
    op = 2'd0; op_u = 1'b1; a = 32'd5; b = 32'd9; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    saw_done = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clock);
      if (done) saw_done = 1'b1;
      if (i == 10) chk("kill_busy_before", 64'(busy), 64'd1);
      if (i == 11) chk("kill_busy_after", 64'(busy), 64'd0);
      start = (i == 5);
      a     = (i == 5) ? 32'd7 : 32'd5;
      kill  = (i == 10);
    end
    chk("kill_no_done", 64'(saw_done), 64'd0);
    chk("kill_hi_held", 64'(hi_out), 64'(ph));
    chk("kill_lo_held", 64'(lo_out), 64'(pl));
    chk("kill_dbz_held", 64'(div_by_zero), 64'(pdz));

    // Back-to-back: start held through the first DONE
    @(negedge clock);
    op = 2'd0; op_u = 1'b1; a = 32'd3; b = 32'd4; start = 1'b1;
    @(posedge clock);
    #1 a = 32'd10; b = 32'd11;
    lat = 0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clock);
      if (done) begin lat = i; break; end
    end
    chk("b2b_first_latency", 64'(lat), 64'd34);
    chk("b2b_first_lo", 64'(lo_out), 64'd12);
    gap = 0; bubble = 1'b0; saw_done = 1'b0;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clock);
      if (!busy) bubble = 1'b1;
      if (done) begin saw_done = 1'b1; break; end
      gap++;
    end
    start = 1'b0;
    chk("b2b_second_done_seen", 64'(saw_done), 64'd1);
    chk("b2b_gap_cycles", 64'(gap), 64'd33);
    chk("b2b_no_idle_bubble", 64'(bubble), 64'd0);
    chk("b2b_second_lo", 64'(lo_out), 64'd110);
    @(negedge clock);
    chk("b2b_idle_after", 64'(busy), 64'd0);

    // Asynchronous reset mid-CALC
    @(negedge clock);
    op = 2'd2; op_u = 1'b1; a = 32'd50; b = 32'd0; start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
    repeat (10) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("async_reset_busy", 64'(busy), 64'd0);
    chk("async_reset_done", 64'(done), 64'd0);
    chk("async_reset_hi", 64'(hi_out), 64'd0);
    chk("async_reset_lo", 64'(lo_out), 64'd0);
    chk("async_reset_dbz", 64'(div_by_zero), 64'd0);
    @(negedge clock);
    reset_n = 1'b1;

    // Random operations against the reference model
    for (int n = 0; n < 150; n++) begin
      ro  = 2'($urandom_range(0, 2));
      ru  = 1'($urandom_range(0, 1));
      ra  = rnd_operand();
      rb  = rnd_operand();
      rhi = $urandom;
      rlo = $urandom;
      exp = model(ro, ru, ra, rb, rhi, rlo);
      do_op(ro, ru, ra, rb, rhi, rlo, rh, rl, rdz, lat, bcnt);
      chk($sformatf("rnd%0d_op%0d_u%0d_latency", n, ro, ru), 64'(lat), 64'd34);
      chk($sformatf("rnd%0d_op%0d_u%0d_a%h_b%h_hilo", n, ro, ru, ra, rb), {rh, rl}, exp[63:0]);
      chk($sformatf("rnd%0d_dbz", n), 64'(rdz), 64'(exp[64]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
